// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: state encoding and
// default timing/scoring parameters.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int unsigned DEF_TICK_DIV     = 65536;
    localparam int unsigned DEF_SERVE_FRAMES = 60;
    localparam int unsigned DEF_WIN_SCORE    = 7;
    localparam int unsigned DEF_SCORE_W      = 4;

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running frame divider: counts 0..TICK_DIV-1 and flags the last count
// as a one-cycle frame tick decoded from the registered count.
module pong_tick_gen
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign frame_tick = (count == LAST);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve delay, play gating, scoring and winner
// detection around a free-running frame tick.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
    parameter int unsigned SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int unsigned WIN_SCORE    = DEF_WIN_SCORE,
    parameter int unsigned SCORE_W      = DEF_SCORE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pause,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               frame_tick,
    output logic               move_en,
    output logic               ball_reset,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic               game_over,
    output logic               winner,
    output logic [2:0]         state
);

    localparam int unsigned SRV_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES + 1) : 1;
    localparam logic [SRV_W-1:0]   SRV_LOAD = SRV_W'(SERVE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    state_t           st;
    logic             start_q;
    logic             start_rise;
    logic [SRV_W-1:0] serve_cnt;

    // Point award that can never pass the winning score.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? WIN : s + SCORE_W'(1);
    endfunction

    pong_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick)
    );

    assign start_rise = start & ~start_q;
    assign move_en    = (st == ST_PLAY) & frame_tick & ~pause;
    assign state      = st;

    // start_q resets high so a button held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            start_q    <= 1'b1;
            serve_cnt  <= '0;
            score_l    <= '0;
            score_r    <= '0;
            serve_dir  <= 1'b1;
            ball_reset <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
        end else begin
            start_q    <= start;
            ball_reset <= 1'b0;
            case (st)
                ST_IDLE: begin
                    score_l <= '0;
                    score_r <= '0;
                    if (start_rise) begin
                        st         <= ST_SERVE;
                        ball_reset <= 1'b1;
                        serve_dir  <= 1'b1;
                        serve_cnt  <= SRV_LOAD;
                    end
                end
                ST_SERVE: begin
                    if (frame_tick) begin
                        serve_cnt <= serve_cnt - SRV_W'(1);
                        if (serve_cnt <= SRV_W'(1)) begin
                            st <= ST_PLAY;
                        end
                    end
                end
                ST_PLAY: begin
                    case ({miss_left, miss_right})
                        2'b10: begin
                            score_r    <= sat_inc(score_r);
                            serve_dir  <= 1'b0;
                            ball_reset <= 1'b1;
                            st         <= ST_POINT;
                        end
                        2'b01: begin
                            score_l    <= sat_inc(score_l);
                            serve_dir  <= 1'b1;
                            ball_reset <= 1'b1;
                            st         <= ST_POINT;
                        end
                        2'b11: begin
                            ball_reset <= 1'b1;
                            st         <= ST_POINT;
                        end
                        default: ;
                    endcase
                end
                ST_POINT: begin
                    if ((score_l == WIN) || (score_r == WIN)) begin
                        st        <= ST_OVER;
                        game_over <= 1'b1;
                        winner    <= (score_r == WIN);
                    end else begin
                        st        <= ST_SERVE;
                        serve_cnt <= SRV_LOAD;
                    end
                end
                ST_OVER: begin
                    if (start_rise) begin
                        st        <= ST_IDLE;
                        score_l   <= '0;
                        score_r   <= '0;
                        game_over <= 1'b0;
                        winner    <= 1'b0;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed table-driven bench for pong_match_ctrl with a short frame divider.
module tb_pong_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, pause, miss_left, miss_right;
    logic       frame_tick, move_en, ball_reset, serve_dir, game_over, winner;
    logic [3:0] score_l, score_r;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    pong_match_ctrl #(
        .TICK_DIV     (4),
        .SERVE_FRAMES (2),
        .WIN_SCORE    (3),
        .SCORE_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pause      (pause),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .frame_tick (frame_tick),
        .move_en    (move_en),
        .ball_reset (ball_reset),
        .serve_dir  (serve_dir),
        .score_l    (score_l),
        .score_r    (score_r),
        .game_over  (game_over),
        .winner     (winner),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, pause, ml, mr;
        int         n;
        logic [2:0] st;
        logic [3:0] sl, sr;
        logic       sdir, brst, go, win, mv, ft;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic s, p, l, r, input int n,
                                input logic [2:0] st, input logic [3:0] sl, sr,
                                input logic sdir, brst, go, win, mv, ft);
        vec_t v;
        v.start = s; v.pause = p; v.ml = l; v.mr = r; v.n = n;
        v.st = st; v.sl = sl; v.sr = sr; v.sdir = sdir; v.brst = brst;
        v.go = go; v.win = win; v.mv = mv; v.ft = ft;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic chk_vec(input int i);
        chk("state",      i, int'(state),      int'(vecs[i].st));
        chk("score_l",    i, int'(score_l),    int'(vecs[i].sl));
        chk("score_r",    i, int'(score_r),    int'(vecs[i].sr));
        chk("serve_dir",  i, int'(serve_dir),  int'(vecs[i].sdir));
        chk("ball_reset", i, int'(ball_reset), int'(vecs[i].brst));
        chk("game_over",  i, int'(game_over),  int'(vecs[i].go));
        chk("winner",     i, int'(winner),     int'(vecs[i].win));
        chk("move_en",    i, int'(move_en),    int'(vecs[i].mv));
        chk("frame_tick", i, int'(frame_tick), int'(vecs[i].ft));
    endtask

    task automatic wait_play(input string name);
        int k;
        k = 0;
        while (state != 3'd2 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(name, 0, int'(state), 2);
    endtask

    initial begin
        //            s p l r  n  st sl sr sd br go wn mv ft     posedge index after apply
        vecs[0]  = mk(1,0,0,0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0); // 2: start held through reset
        vecs[1]  = mk(0,0,0,0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1); // 3
        vecs[2]  = mk(1,0,0,0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0); // 4: start edge
        vecs[3]  = mk(1,0,0,0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0); // 5
        vecs[4]  = mk(0,0,0,0, 6, 1, 0, 0, 1, 0, 0, 0, 0, 1); // 11
        vecs[5]  = mk(0,0,0,0, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0); // 12: second tick -> PLAY
        vecs[6]  = mk(0,0,0,0, 3, 2, 0, 0, 1, 0, 0, 0, 1, 1); // 15
        vecs[7]  = mk(0,1,0,0, 4, 2, 0, 0, 1, 0, 0, 0, 0, 1); // 19: paused
        vecs[8]  = mk(0,0,0,0, 4, 2, 0, 0, 1, 0, 0, 0, 1, 1); // 23
        vecs[9]  = mk(0,0,1,0, 1, 3, 0, 1, 0, 1, 0, 0, 0, 0); // 24: miss_left
        vecs[10] = mk(0,0,0,0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0); // 25
        vecs[11] = mk(0,0,0,0, 7, 2, 0, 1, 0, 0, 0, 0, 0, 0); // 32
        vecs[12] = mk(0,0,1,1, 1, 3, 0, 1, 0, 1, 0, 0, 0, 0); // 33: both misses
        vecs[13] = mk(0,0,0,0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0); // 34
        vecs[14] = mk(0,0,0,0, 6, 2, 0, 1, 0, 0, 0, 0, 0, 0); // 40
        vecs[15] = mk(0,0,0,1, 1, 3, 1, 1, 1, 1, 0, 0, 0, 0); // 41
        vecs[16] = mk(0,0,0,0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0); // 42
        vecs[17] = mk(0,0,0,0, 6, 2, 1, 1, 1, 0, 0, 0, 0, 0); // 48
        vecs[18] = mk(0,0,0,1, 1, 3, 2, 1, 1, 1, 0, 0, 0, 0); // 49
        vecs[19] = mk(0,0,0,0, 1, 1, 2, 1, 1, 0, 0, 0, 0, 0); // 50
        vecs[20] = mk(0,0,0,0, 6, 2, 2, 1, 1, 0, 0, 0, 0, 0); // 56
        vecs[21] = mk(0,0,0,1, 1, 3, 3, 1, 1, 1, 0, 0, 0, 0); // 57: winning point
        vecs[22] = mk(0,0,0,0, 1, 4, 3, 1, 1, 0, 1, 0, 0, 0); // 58: OVER, left wins
        vecs[23] = mk(0,0,1,0, 1, 4, 3, 1, 1, 0, 1, 0, 0, 1); // 59: miss ignored
        vecs[24] = mk(0,0,0,1, 1, 4, 3, 1, 1, 0, 1, 0, 0, 0); // 60: miss ignored
        vecs[25] = mk(1,0,0,0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // 61: restart -> IDLE
        vecs[26] = mk(0,0,0,0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // 62

        rst_n = 1'b0; start = 1'b1; pause = 1'b0; miss_left = 1'b0; miss_right = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state",      0, int'(state),      0);
        chk("rst_serve_dir",  0, int'(serve_dir),  1);
        chk("rst_ball_reset", 0, int'(ball_reset), 0);
        chk("rst_frame_tick", 0, int'(frame_tick), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) begin
            start      = vecs[i].start;
            pause      = vecs[i].pause;
            miss_left  = vecs[i].ml;
            miss_right = vecs[i].mr;
            repeat (vecs[i].n) @(posedge clk);
            @(negedge clk);
            chk_vec(i);
        end

        // Score a point, reach PLAY again, then reset asynchronously mid-cycle.
        start = 1'b1;
        wait_play("seq_play1");
        start = 1'b0;
        miss_left = 1'b1;
        @(negedge clk);
        miss_left = 1'b0;
        chk("seq_score_r", 0, int'(score_r), 1);
        chk("seq_sdir",    0, int'(serve_dir), 0);
        wait_play("seq_play2");
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state",     0, int'(state),      0);
        chk("arst_score_r",   0, int'(score_r),    0);
        chk("arst_serve_dir", 0, int'(serve_dir),  1);
        chk("arst_move_en",   0, int'(move_en),    0);
        chk("arst_tick",      0, int'(frame_tick), 0);
        chk("arst_over",      0, int'(game_over),  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
